// File: rtl/kogge_stone_sub_pipe.sv
// Pipelined N-bit subtractor built on a Kogge-Stone parallel-prefix carry
// network. The subtraction is a + ~b + 1. Stage 0 captures the bitwise
// generate/propagate terms. Each of the following LOG2N stages resolves one
// prefix level. Every stage carries a valid bit. The whole pipe advances
// together under one enable, so a stalled consumer freezes every stage.
module kogge_stone_sub_pipe #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         borrow,
   output logic         overflow
);

   localparam int LOG2N = $clog2(N);
   localparam int L     = LOG2N + 1;

   // Per-stage registers. Index 0 is the acceptance register.
   // Index L-1 is the final prefix level that drives the outputs.
   logic [N-1:0] g_q   [0:L-1];
   logic [N-1:0] p_q   [0:L-1];
   // The half-sum travels down the pipe inverted (a ^ b rather than a ^ ~b).
   // An all-zero reset state then yields diff = 0xFF..FE.
   logic [N-1:0] x_q   [0:L-1];
   logic [L-1:0] valid_q;
   logic [L-1:0] a_msb_q;
   logic [L-1:0] b_msb_q;

   logic [N-1:0] p_in;
   logic [N-1:0] g_in;
   logic [N-1:0] g_nxt [1:L-1];
   logic [N-1:0] p_nxt [1:L-1];
   logic         en;

   // Global advance enable. Every stage can move unless a result is waiting.
   assign en        = ~valid_q[L-1] | out_ready;
   assign in_ready  = en;
   assign out_valid = valid_q[L-1];

   // Bitwise propagate/generate for a + ~b. The +1 carry-in is folded into bit 0.
   always_comb begin
      p_in    = a ^ ~b;
      g_in    = a & ~b;
      g_in[0] = g_in[0] | p_in[0];
   end

   // Kogge-Stone prefix levels. Level s combines each bit with the bit 2^(s-1) below it.
   always_comb begin
      for (int s = 1; s < L; s++) begin
         g_nxt[s] = g_q[s-1];
         p_nxt[s] = p_q[s-1];
         for (int i = (1 << (s - 1)); i < N; i++) begin
            g_nxt[s][i] = g_q[s-1][i] | (p_q[s-1][i] & g_q[s-1][i - (1 << (s - 1))]);
            p_nxt[s][i] = p_q[s-1][i] & p_q[s-1][i - (1 << (s - 1))];
         end
      end
   end

   // Pipeline registers. Reset clears everything; otherwise all stages shift together when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < L; s++) begin
            g_q[s] <= '0;
            p_q[s] <= '0;
            x_q[s] <= '0;
         end
         valid_q <= '0;
         a_msb_q <= '0;
         b_msb_q <= '0;
      end else if (en) begin
         g_q[0]  <= g_in;
         p_q[0]  <= p_in;
         x_q[0]  <= a ^ b;
         for (int s = 1; s < L; s++) begin
            g_q[s] <= g_nxt[s];
            p_q[s] <= p_nxt[s];
            x_q[s] <= x_q[s-1];
         end
         valid_q <= {valid_q[L-2:0], in_valid};
         a_msb_q <= {a_msb_q[L-2:0], a[N-1]};
         b_msb_q <= {b_msb_q[L-2:0], b[N-1]};
      end
   end

   // Result formation from the final stage.
   // The carry into bit i is the group generate of bits below i; bit 0 sees carry-in 1.
   always_comb begin
      diff     = ~x_q[L-1] ^ {g_q[L-1][N-2:0], 1'b1};
      borrow   = ~g_q[L-1][N-1];
      overflow = (a_msb_q[L-1] != b_msb_q[L-1]) && (diff[N-1] != a_msb_q[L-1]);
   end

endmodule

// File: tb/tb_kogge_stone_sub_pipe.sv
// Self-checking bench for kogge_stone_sub_pipe at N = 8 (latency 4).
// Expected results come from plain integer arithmetic on the operands.
// A queue of pending results tracks acceptance order.
module tb_kogge_stone_sub_pipe;

   localparam int N = 8;
   localparam int L = 4;

   typedef struct packed {
      logic [N-1:0] diff;
      logic         borrow;
      logic         overflow;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] diff;
   logic         borrow;
   logic         overflow;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   kogge_stone_sub_pipe #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .overflow  (overflow)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Reference subtraction: modular difference, unsigned compare, signed range test.
   function automatic res_t ref_sub(input logic [N-1:0] x, input logic [N-1:0] y);
      res_t r;
      int   sx;
      int   sy;
      int   sd;
      sx = $signed(x);
      sy = $signed(y);
      sd = sx - sy;
      r.diff     = N'(int'(x) - int'(y));
      r.borrow   = (x < y);
      r.overflow = (sd > 127) || (sd < -128);
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ({out_valid, diff, borrow, overflow} !== {1'b0, 8'hFE, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got v=%b d=%h b=%b o=%b expected v=0 d=fe b=1 o=0",
                  out_valid, diff, borrow, overflow);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      logic [N-1:0] ta [5] = '{8'h50, 8'h00, 8'h05, 8'h80, 8'h7F};
      logic [N-1:0] tb [5] = '{8'h20, 8'h01, 8'h05, 8'h01, 8'hFF};
      res_t         te [5] = '{{8'h30, 1'b0, 1'b0}, {8'hFF, 1'b1, 1'b0}, {8'h00, 1'b0, 1'b0},
                               {8'h7F, 1'b0, 1'b1}, {8'h80, 1'b1, 1'b1}};
      res_t got;
      out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         in_valid = 1'b1; a = ta[v]; b = tb[v];
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL directed_ready[%0d]: got %b expected 1", v, in_ready);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k < 3) begin
               if (out_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL directed_early[%0d]: out_valid=%b after %0d edges expected 0", v, out_valid, k);
               end
            end else begin
               got = {diff, borrow, overflow};
               if (out_valid !== 1'b1 || got !== te[v]) begin
                  errors++;
                  $display("FAIL directed_result[%0d]: got v=%b %h/%b/%b expected v=1 %h/%b/%b", v,
                           out_valid, got.diff, got.borrow, got.overflow, te[v].diff, te[v].borrow, te[v].overflow);
               end
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] va [8];
      logic [N-1:0] vb [8];
      res_t exp;
      for (int j = 0; j < 8; j++) begin
         va[j] = N'($urandom);
         vb[j] = N'($urandom);
      end
      out_ready = 1'b1;
      for (int t = 0; t < 12; t++) begin
         if (t < 8) begin
            in_valid = 1'b1; a = va[t]; b = vb[t];
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         checks++;
         if (t >= 3 && t - 3 < 8) begin
            exp = ref_sub(va[t-3], vb[t-3]);
            if (out_valid !== 1'b1 || {diff, borrow, overflow} !== exp) begin
               errors++;
               $display("FAIL b2b_result[%0d]: got v=%b %h/%b/%b expected v=1 %h/%b/%b", t - 3,
                        out_valid, diff, borrow, overflow, exp.diff, exp.borrow, exp.overflow);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle[%0d]: out_valid=%b expected 0", t, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int   sent = 0;
      int   recv = 0;
      logic stalled = 1'b0;
      res_t held;
      res_t exp;
      exp_q.delete();
      for (int c = 0; c < 30; c++) begin
         in_valid  = (sent < 6);
         a         = N'($urandom);
         b         = N'($urandom);
         out_ready = !(c >= 2 && c < 7);
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || {diff, borrow, overflow} !== held) begin
               errors++;
               $display("FAIL bp_stable: got v=%b %h/%b/%b expected v=1 %h/%b/%b",
                        out_valid, diff, borrow, overflow, held.diff, held.borrow, held.overflow);
            end
         end
         stalled = out_valid && !out_ready;
         held    = {diff, borrow, overflow};
         if (stalled) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready: got %b expected 0 while stalled", in_ready);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: unexpected result %h", diff);
            end else begin
               exp = exp_q.pop_front();
               recv++;
               if ({diff, borrow, overflow} !== exp) begin
                  errors++;
                  $display("FAIL bp_result[%0d]: got %h/%b/%b expected %h/%b/%b", recv - 1,
                           diff, borrow, overflow, exp.diff, exp.borrow, exp.overflow);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_sub(a, b));
            sent++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (recv != 6 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d results, %0d pending, expected 6 and 0", recv, exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      logic [N-1:0] pa [2];
      logic [N-1:0] pb [2];
      res_t exp;
      out_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         in_valid = 1'b1; a = N'($urandom); b = N'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b1; in_valid = 1'b1; a = N'($urandom); b = N'($urandom);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flush[%0d]: out_valid=%b expected 0", k, out_valid);
         end
         @(posedge clk); #1;
      end
      for (int j = 0; j < 2; j++) begin
         pa[j] = N'($urandom); pb[j] = N'($urandom);
         in_valid = 1'b1; a = pa[j]; b = pb[j];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int m = 0; m < 5; m++) begin
         checks++;
         if (m == 2 || m == 3) begin
            exp = ref_sub(pa[m-2], pb[m-2]);
            if (out_valid !== 1'b1 || {diff, borrow, overflow} !== exp) begin
               errors++;
               $display("FAIL midrst_result[%0d]: got v=%b %h/%b/%b expected v=1 %h/%b/%b", m - 2,
                        out_valid, diff, borrow, overflow, exp.diff, exp.borrow, exp.overflow);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle[%0d]: out_valid=%b expected 0", m, out_valid);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic stalled = 1'b0;
      res_t held;
      res_t exp;
      exp_q.delete();
      for (int c = 0; c < 20040; c++) begin
         if (c < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         a = N'($urandom);
         b = N'($urandom);
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || {diff, borrow, overflow} !== held) begin
               errors++;
               $display("FAIL rand_stable at %0d: got v=%b %h expected v=1 %h", c, out_valid, diff, held.diff);
            end
         end
         stalled = out_valid && !out_ready;
         held    = {diff, borrow, overflow};
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra at %0d: unexpected result %h", c, diff);
            end else begin
               exp = exp_q.pop_front();
               if ({diff, borrow, overflow} !== exp) begin
                  errors++;
                  $display("FAIL rand_result at %0d: got %h/%b/%b expected %h/%b/%b", c,
                           diff, borrow, overflow, exp.diff, exp.borrow, exp.overflow);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b));
         @(posedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain: got %0d pending, out_valid=%b expected 0 and 0", exp_q.size(), out_valid);
      end
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
